// File: rtl/mont_pkg.sv
// Shared types and defaults for the Montgomery
// final conditional-subtraction stage.
package mont_pkg;

  localparam int WIDTH_DEF = 256;
  localparam int LIMB_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    SEL
  } fs_state_t;

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/mont_final_sub_limb_sub.sv
// Combinational LIMB-bit subtractor with borrow
// in/out, one slice of the serial M - P chain.
module limb_sub #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            bin,
  output logic [LIMB-1:0] d,
  output logic            bout
);

  logic [LIMB:0] ext;

  // Extra top bit of the extended difference is the borrow
  always_comb begin
    ext = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
    d = ext[LIMB-1:0];
    bout = ext[LIMB];
  end

endmodule

// File: rtl/mont_final_sub.sv
// Reduces a Montgomery product {M_carry,M} < 2P to
// R = result mod P using a limb-serial subtractor.
module mont_final_sub
  import mont_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LIMB  = LIMB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic             M_carry,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] R,
  output logic             sub_flag,
  output logic             busy,
  output logic             done
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  fs_state_t        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             sub_flag_q, sub_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LIMB-1:0]  a_limb;
  logic [LIMB-1:0]  b_limb;
  logic [LIMB-1:0]  d_limb;
  logic             bout;
  logic             last_limb;
  logic             neg;

  // Select the current limb of the latched operands
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < NLIMB; i++) begin
      if (idx_q == IW'(i)) begin
        a_limb = m_q[i*LIMB +: LIMB];
        b_limb = p_q[i*LIMB +: LIMB];
      end
    end
  end

  limb_sub #(
    .LIMB(LIMB)
  ) u_limb_sub (
    .a   (a_limb),
    .b   (b_limb),
    .bin (borrow_q),
    .d   (d_limb),
    .bout(bout)
  );

  assign last_limb = (idx_q == IW'(NLIMB-1));
  assign neg = borrow_q & ~carry_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = SUB;
      SUB:  if (last_limb) state_d = SEL;
      SEL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    carry_d    = carry_q;
    m_d        = m_q;
    p_d        = p_q;
    diff_d     = diff_q;
    r_d        = r_q;
    sub_flag_d = sub_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d      = M;
          carry_d  = M_carry;
          p_d      = P;
          idx_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      SUB: begin
        diff_d   = {d_limb, diff_q[WIDTH-1:LIMB]};
        borrow_d = bout;
        idx_d    = idx_q + 1'b1;
      end
      SEL: begin
        r_d        = neg ? m_q : diff_q;
        sub_flag_d = ~neg;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      carry_q    <= 1'b0;
      m_q        <= '0;
      p_q        <= '0;
      diff_q     <= '0;
      r_q        <= '0;
      sub_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      carry_q    <= carry_d;
      m_q        <= m_d;
      p_q        <= p_d;
      diff_q     <= diff_d;
      r_q        <= r_d;
      sub_flag_q <= sub_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign R        = r_q;
  assign sub_flag = sub_flag_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
